// File: rtl/multi_arbiter.sv
// Round-robin arbiter that serialises four requesters onto a single shared multiplier.
// It runs one transaction at a time (load, start, wait for the result, read back, respond) and aborts on timeout.
module multi_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] opA,
  input  logic [NREQ*DATA_W-1:0] opB,
  output logic [NREQ-1:0]        grant,
  output logic                   resp_valid,
  output logic [1:0]             resp_id,
  output logic [DATA_W-1:0]      resp_msb,
  output logic [DATA_W-1:0]      resp_lsb,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [DATA_W-1:0]      m_dataIn0,
  output logic [DATA_W-1:0]      m_dataIn1,
  output logic                   m_bufferEN,
  output logic                   m_bufferRD,
  output logic                   m_mStart,
  input  logic                   m_mReady,
  input  logic                   m_FULL0,
  input  logic                   m_FULL1,
  input  logic [DATA_W-1:0]      m_dataOutMSB,
  input  logic [DATA_W-1:0]      m_dataOutLSB
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] READ  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]        stateQ, stateNxt;
  logic [IDX_W-1:0]  rrPtr, rrPtrNxt;
  logic [IDX_W-1:0]  ownerIdx, ownerIdxNxt;
  logic [CNT_W-1:0]  waitCnt, waitCntNxt;

  logic [NREQ-1:0]   grantNxt;
  logic              respValidNxt, busyNxt, timeoutErrNxt;
  logic [1:0]        respIdNxt;
  logic [DATA_W-1:0] respMsbNxt, respLsbNxt;
  logic [DATA_W-1:0] dataIn0Nxt, dataIn1Nxt;
  logic              bufferEnNxt, bufferRdNxt, mStartNxt;

  logic              winFound;
  logic [IDX_W-1:0]  winIdx, cand;
  logic [DATA_W-1:0] winOpA, winOpB;

  // First requesting index at or above rrPtr, wrapping mod 4
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    winOpA   = '0;
    winOpB   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = rrPtr + IDX_W'(i);
      if (!winFound && req[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
        winOpA   = opA[DATA_W*int'(cand) +: DATA_W];
        winOpB   = opB[DATA_W*int'(cand) +: DATA_W];
      end
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    stateNxt      = stateQ;
    rrPtrNxt      = rrPtr;
    ownerIdxNxt   = ownerIdx;
    waitCntNxt    = waitCnt;
    grantNxt      = '0;
    respValidNxt  = 1'b0;
    timeoutErrNxt = 1'b0;
    respIdNxt     = resp_id;
    respMsbNxt    = resp_msb;
    respLsbNxt    = resp_lsb;
    dataIn0Nxt    = m_dataIn0;
    dataIn1Nxt    = m_dataIn1;
    bufferEnNxt   = 1'b0;
    bufferRdNxt   = 1'b0;
    mStartNxt     = 1'b0;

    case (stateQ)
      IDLE: begin
        if (winFound && !m_FULL0 && !m_FULL1) begin
          stateNxt    = LOAD;
          ownerIdxNxt = winIdx;
          rrPtrNxt    = winIdx + IDX_W'(1);
          dataIn0Nxt  = winOpA;
          dataIn1Nxt  = winOpB;
          grantNxt    = NREQ'(1) << winIdx;
          bufferEnNxt = 1'b1;
        end
      end
      LOAD: begin
        stateNxt  = START;
        mStartNxt = 1'b1;
      end
      START: begin
        stateNxt   = WAIT;
        waitCntNxt = '0;
      end
      WAIT: begin
        // A result on the expiry cycle wins over the abort
        if (m_mReady) begin
          stateNxt    = READ;
          respMsbNxt  = m_dataOutMSB;
          respLsbNxt  = m_dataOutLSB;
          bufferRdNxt = 1'b1;
        end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
          stateNxt      = IDLE;
          timeoutErrNxt = 1'b1;
        end else begin
          waitCntNxt = waitCnt + CNT_W'(1);
        end
      end
      READ: begin
        stateNxt     = DONE;
        respValidNxt = 1'b1;
        respIdNxt    = ownerIdx;
      end
      DONE: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase

    busyNxt = (stateNxt != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stateQ      <= IDLE;
      rrPtr       <= '0;
      ownerIdx    <= '0;
      waitCnt     <= '0;
      grant       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_msb    <= '0;
      resp_lsb    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      m_dataIn0   <= '0;
      m_dataIn1   <= '0;
      m_bufferEN  <= 1'b0;
      m_bufferRD  <= 1'b0;
      m_mStart    <= 1'b0;
    end else begin
      stateQ      <= stateNxt;
      rrPtr       <= rrPtrNxt;
      ownerIdx    <= ownerIdxNxt;
      waitCnt     <= waitCntNxt;
      grant       <= grantNxt;
      resp_valid  <= respValidNxt;
      resp_id     <= respIdNxt;
      resp_msb    <= respMsbNxt;
      resp_lsb    <= respLsbNxt;
      busy        <= busyNxt;
      timeout_err <= timeoutErrNxt;
      m_dataIn0   <= dataIn0Nxt;
      m_dataIn1   <= dataIn1Nxt;
      m_bufferEN  <= bufferEnNxt;
      m_bufferRD  <= bufferRdNxt;
      m_mStart    <= mStartNxt;
    end
  end

endmodule

// File: tb/tb_multi_arbiter.sv
// Bench for multi_arbiter: table of arbitration vectors plus hand-written corner sequences.
// Responses are checked against a scoreboard of products computed from the bench's own operands.
module tb_multi_arbiter;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;

  logic              Clk, Rst;
  logic [3:0]        req;
  logic [4*DATA_W-1:0] opA, opB;
  logic [3:0]        grant;
  logic              resp_valid, busy, timeout_err;
  logic [1:0]        resp_id;
  logic [DATA_W-1:0] resp_msb, resp_lsb, m_dataIn0, m_dataIn1;
  logic              m_bufferEN, m_bufferRD, m_mStart;
  logic              m_mReady, m_FULL0, m_FULL1;
  logic [DATA_W-1:0] m_dataOutMSB, m_dataOutLSB;

  logic [DATA_W-1:0] opAArr [4];
  logic [DATA_W-1:0] opBArr [4];

  typedef struct {
    logic [1:0]  id;
    logic [63:0] prod;
  } resp_t;

  typedef struct {
    logic [3:0] reqV;
    int         expIdx;
    int         delay;
    bit         keep;
  } vec_t;

  resp_t sb [$];
  vec_t  tbl [14];
  int    checks = 0;
  int    errors = 0;
  bit    toExpected = 1'b0;

  assign opA = {opAArr[3], opAArr[2], opAArr[1], opAArr[0]};
  assign opB = {opBArr[3], opBArr[2], opBArr[1], opBArr[0]};

  multi_arbiter #(.DATA_W(DATA_W), .NREQ(4), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .opA(opA), .opB(opB),
    .grant(grant), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_msb(resp_msb), .resp_lsb(resp_lsb), .busy(busy), .timeout_err(timeout_err),
    .m_dataIn0(m_dataIn0), .m_dataIn1(m_dataIn1),
    .m_bufferEN(m_bufferEN), .m_bufferRD(m_bufferRD), .m_mStart(m_mStart),
    .m_mReady(m_mReady), .m_FULL0(m_FULL0), .m_FULL1(m_FULL1),
    .m_dataOutMSB(m_dataOutMSB), .m_dataOutLSB(m_dataOutLSB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Response scoreboard and always-on protocol checks
  always @(negedge Clk) begin
    if (Rst) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedResp actual id=%0d expected none", resp_id);
        end else begin
          resp_t e;
          e = sb.pop_front();
          check("respId", 64'(resp_id), 64'(e.id));
          check("respData", {resp_msb, resp_lsb}, e.prod);
        end
      end
      if (timeout_err && !toExpected) begin
        checks++;
        errors++;
        $display("FAIL unexpectedTimeout actual=1 expected=0 @%0t", $time);
      end
      if ($countones({m_bufferEN, m_mStart, m_bufferRD}) > 1) begin
        checks++;
        errors++;
        $display("FAIL ctlExclusive actual=%b expected onehot0", {m_bufferEN, m_mStart, m_bufferRD});
      end
    end
  end

  // One transaction, entered at a negedge in IDLE with req already driven; delay<0 means timeout
  task automatic doTxn(input int expIdx, input int delay, input bit keep, input bit fullMid);
    int n;
    logic [63:0] prod;
    resp_t e;
    prod = 64'(opAArr[expIdx]) * 64'(opBArr[expIdx]);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (grant == 4'b0 && n < 4);
    check("grant", 64'(grant), 64'(4'b0001 << expIdx));
    check("grantLatency", 64'(n), 64'(1));
    check("loadCtl", 64'({busy, m_bufferEN, m_mStart, m_bufferRD}), 64'(4'b1100));
    check("loadData", {m_dataIn0, m_dataIn1}, {opAArr[expIdx], opBArr[expIdx]});
    if (!keep) req = 4'b0;
    if (fullMid) m_FULL1 = 1'b1;
    if (delay >= 0) begin
      e.id = 2'(expIdx);
      e.prod = prod;
      sb.push_back(e);
    end
    @(negedge Clk);
    check("startCtl", 64'({grant, m_bufferEN, m_mStart, m_bufferRD}), 64'(7'b0000_010));
    if (delay > 0) begin
      m_mReady = 1'b1;
      {m_dataOutMSB, m_dataOutLSB} = 64'hDEAD_BEEF_0BAD_F00D;
    end
    @(negedge Clk);
    m_mReady = 1'b0;
    if (delay < 0) begin
      toExpected = 1'b1;
      n = 1;
      while (!timeout_err && n < TIMEOUT + 8) begin
        @(negedge Clk);
        n++;
      end
      check("timeoutLatency", 64'(n), 64'(TIMEOUT + 1));
      check("timeoutState", 64'({timeout_err, busy, resp_valid}), 64'(3'b100));
      @(negedge Clk);
      toExpected = 1'b0;
      check("timeoutPulse", 64'({timeout_err, busy}), 64'(2'b00));
    end else begin
      repeat (delay) @(negedge Clk);
      m_mReady = 1'b1;
      {m_dataOutMSB, m_dataOutLSB} = 64'(m_dataIn0) * 64'(m_dataIn1);
      @(negedge Clk);
      m_mReady = 1'b0;
      {m_dataOutMSB, m_dataOutLSB} = {$urandom, $urandom};
      check("readCtl", 64'({m_bufferRD, resp_valid, busy}), 64'(3'b101));
      check("capture", {resp_msb, resp_lsb}, prod);
      @(negedge Clk);
      check("doneValid", 64'(resp_valid), 64'(1));
      @(negedge Clk);
      check("idleAfter", 64'({resp_valid, busy, grant}), 64'(0));
      check("holdResult", {resp_msb, resp_lsb}, prod);
      check("holdData", {m_dataIn0, m_dataIn1}, {opAArr[expIdx], opBArr[expIdx]});
    end
    m_FULL1 = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 0, 0, 1'b1};
    tbl[1]  = '{4'b1111, 1, 1, 1'b1};
    tbl[2]  = '{4'b1111, 2, 2, 1'b1};
    tbl[3]  = '{4'b1111, 3, 3, 1'b1};
    tbl[4]  = '{4'b1111, 0, 0, 1'b1};
    tbl[5]  = '{4'b1111, 1, 1, 1'b1};
    tbl[6]  = '{4'b1111, 2, 2, 1'b1};
    tbl[7]  = '{4'b1111, 3, 3, 1'b1};
    tbl[8]  = '{4'b0001, 0, 2, 1'b0};
    tbl[9]  = '{4'b0101, 2, 0, 1'b0};
    tbl[10] = '{4'b0011, 0, 5, 1'b0};
    tbl[11] = '{4'b1001, 3, 1, 1'b0};
    tbl[12] = '{4'b1110, 1, 0, 1'b1};
    tbl[13] = '{4'b1110, 2, 3, 1'b0};

    opAArr[0] = 32'd4;
    opBArr[0] = 32'd8;
    for (int i = 1; i < 4; i++) begin
      opAArr[i] = $urandom;
      opBArr[i] = $urandom;
    end

    Rst = 1'b0;
    req = 4'b0;
    m_mReady = 1'b0;
    m_FULL0 = 1'b0;
    m_FULL1 = 1'b0;
    m_dataOutMSB = '0;
    m_dataOutLSB = '0;

    repeat (2) @(negedge Clk);
    check("rstCtl", 64'({grant, resp_valid, timeout_err, busy, m_bufferEN, m_bufferRD, m_mStart}), 64'(0));
    check("rstData", {resp_msb, resp_lsb}, 64'(0));
    check("rstOps", {m_dataIn0, m_dataIn1}, 64'(0));
    Rst = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 14; i++) begin
      req = tbl[i].reqV;
      doTxn(tbl[i].expIdx, tbl[i].delay, tbl[i].keep, 1'b0);
    end

    // Back-pressure: FULL blocks acceptance only in IDLE
    m_FULL0 = 1'b1;
    req = 4'b0010;
    repeat (3) begin
      @(negedge Clk);
      check("fullBlocks", 64'({grant, busy}), 64'(0));
    end
    m_FULL0 = 1'b0;
    doTxn(1, 0, 1'b0, 1'b1);

    // Timeout, then normal service
    req = 4'b0100;
    doTxn(2, -1, 1'b0, 1'b0);
    req = 4'b1000;
    doTxn(3, 0, 1'b0, 1'b0);

    // Result arriving on the expiry cycle
    req = 4'b0001;
    doTxn(0, TIMEOUT - 1, 1'b0, 1'b0);

    // Reset while waiting on the multiplier
    req = 4'b0010;
    @(negedge Clk);
    check("rwGrant", 64'(grant), 64'(4'b0010));
    req = 4'b0;
    repeat (2) @(negedge Clk);
    check("rwInWait", 64'(busy), 64'(1));
    #2 Rst = 1'b0;
    #1;
    check("rwCtl", 64'({grant, resp_valid, timeout_err, busy, m_bufferEN, m_bufferRD, m_mStart, resp_id}), 64'(0));
    check("rwData", {resp_msb, resp_lsb}, 64'(0));
    check("rwOps", {m_dataIn0, m_dataIn1}, 64'(0));
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      check("rwQuiet", 64'({busy, resp_valid, timeout_err}), 64'(0));
    end
    req = 4'b1010;
    doTxn(1, 0, 1'b0, 1'b0);
    req = 4'b1000;
    doTxn(3, 1, 1'b0, 1'b0);

    repeat (2) @(negedge Clk);
    check("sbEmpty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_arbiter.md
MULTI_ARBITER -- requirements
Module: multi_arbiter

Interface
REQ-001 Parameter DATA_W, 32, operand/result half-word width (matches multiplier port width).
REQ-002 Parameter NREQ, 4, number of requesters; fixed at 4, so the requester index is 2 bits.
REQ-003 Parameter TIMEOUT, 64, maximum number of WAIT cycles before abort.
REQ-004 Clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 Rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  4  per-requester request level.
REQ-007 opA, opB  in  4*DATA_W each  flattened operands; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 grant  out  4  one-hot acceptance pulse.
REQ-009 resp_valid  out  1  result pulse.
REQ-010 resp_id  out  2  index of the requester that owns the result.
REQ-011 resp_msb, resp_lsb  out  DATA_W each  product halves.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 timeout_err  out  1  abort pulse.
REQ-014 m_dataIn0, m_dataIn1  out  DATA_W each  operands to the multiplier.
REQ-015 m_bufferEN, m_bufferRD, m_mStart  out  1 each  multiplier controls.
REQ-016 m_mReady, m_FULL0, m_FULL1  in  1 each  multiplier status.
REQ-017 m_dataOutMSB, m_dataOutLSB  in  DATA_W each  multiplier result.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, START, WAIT, READ, DONE.
REQ-019 IDLE SHALL advance to LOAD when |req is high and both m_FULL0 and m_FULL1 are low; otherwise it SHALL hold.
REQ-020 The winner SHALL be the first requester with req high, scanning upward (mod 4) from pointer rr_ptr.
REQ-021 On the IDLE->LOAD edge the block SHALL:
- latch the winner index and its opA/opB;
- set rr_ptr = winner+1 (mod 4).
REQ-022 grant SHALL be one-hot on the winner for exactly the LOAD cycle and zero otherwise.
REQ-023 In LOAD, m_dataIn0/m_dataIn1 SHALL carry the latched operands and m_bufferEN=1 for one cycle; next state is START.
REQ-024 m_dataIn0/m_dataIn1 SHALL hold the latched operands from LOAD until the next grant.
REQ-025 In START, m_mStart=1 for one cycle; next state is WAIT.
REQ-026 In WAIT:
- a cycle counter SHALL run;
- m_mReady=1 SHALL capture m_dataOutMSB/LSB into resp_msb/resp_lsb and go to READ;
- counter reaching TIMEOUT with m_mReady low SHALL go to IDLE with timeout_err=1 for one cycle, no resp_valid.
REQ-027 In READ, m_bufferRD=1 for one cycle; next state is DONE.
REQ-028 In DONE, resp_valid=1 with resp_id=latched index for one cycle; next state is IDLE.
REQ-029 resp_msb/resp_lsb SHALL hold their value until the next capture.
REQ-030 Minimum latency from the accepting edge to resp_valid SHALL be 4 cycles plus the m_mReady wait.
REQ-031 req changes outside IDLE SHALL be ignored.
REQ-032 A req still high after its grant SHALL be treated as a new request.
REQ-033 The FULL check applies only in IDLE; FULL rising mid-transaction SHALL NOT abort it.
REQ-034 m_mReady outside WAIT SHALL be ignored.
REQ-035 m_mReady arriving on the same cycle as the timeout expiry SHALL take precedence (result captured, no error).
REQ-036 m_bufferEN, m_mStart and m_bufferRD SHALL never be asserted in the same cycle.

Reset
REQ-037 Rst low SHALL immediately force:
- state IDLE, rr_ptr=0;
- grant, resp_valid, timeout_err, busy, m_bufferEN, m_bufferRD, m_mStart = 0;
- resp_id, resp_msb, resp_lsb, m_dataIn0, m_dataIn1, WAIT counter = 0.
REQ-038 Reset mid-transaction SHALL discard the transaction with no resp_valid and no timeout_err.
REQ-039 First arbitration after reset SHALL favour requester 0.

Verification
REQ-040 Single request: req=0001, opA0=4, opB0=8, mReady 3 cycles after mStart with result 0/32 -> grant=0001 one cycle, control order bufferEN, mStart, bufferRD, then resp_valid with id 0, msb 0, lsb 32.
REQ-041 Round robin: req=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-042 Back-pressure: FULL0=1 with req=0010 -> no grant, busy=0; FULL0 cleared -> grant=0010 on the next edge.
REQ-043 Timeout: mReady held low -> timeout_err pulses exactly TIMEOUT cycles after WAIT entry, no resp_valid, busy=0 afterwards; the next request is served normally.
REQ-044 Reset in WAIT: Rst low for one cycle -> all outputs zero at once, no response; then req=1000 with rr_ptr=0 -> grant=1000.
REQ-045 Tie at expiry: mReady=1 on the expiry cycle -> resp_valid asserted, timeout_err stays 0.
